// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration helpers for the sync_fifo_param family.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem_dp
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, optional
// first-word-fall-through output, sticky error flags and synchronous flush.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo_param: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end
  if (FWFT > FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // All flags decode the registered count, so they move one cycle after the edge.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    rd_acc   = rd_en && !empty && !flush;
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    wr_acc   = wr_en && (!full || rd_acc) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_W'(1);
      end
      if (wr_en && full && !rd_acc) ovf_d = 1'b1;
      if (rd_en && empty)           unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : mem_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_rdata;
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-mode and an FWFT instance side by side.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s_flush, s_wr, s_rd;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_flush, f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_err    = 0;

  sync_fifo_param #(
    .DATA_W (8),
    .DEPTH  (16),
    .FWFT   (0)
  ) u_std (
    .clk          (clk),
    .rst          (rst),
    .flush        (s_flush),
    .wr_en        (s_wr),
    .data_in      (s_din),
    .rd_en        (s_rd),
    .data_out     (s_dout),
    .full         (s_full),
    .empty        (s_empty),
    .almost_full  (s_af),
    .almost_empty (s_ae),
    .count        (s_count),
    .overflow     (s_ovf),
    .underflow    (s_unf)
  );

  sync_fifo_param #(
    .DATA_W (8),
    .DEPTH  (16),
    .FWFT   (1)
  ) u_fwft (
    .clk          (clk),
    .rst          (rst),
    .flush        (f_flush),
    .wr_en        (f_wr),
    .data_in      (f_din),
    .rd_en        (f_rd),
    .data_out     (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .count        (f_count),
    .overflow     (f_ovf),
    .underflow    (f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_std_reset(input string tag);
    chk({tag, " count"}, s_count, 0);
    chk({tag, " empty"}, s_empty, 1);
    chk({tag, " full"}, s_full, 0);
    chk({tag, " almost_empty"}, s_ae, 1);
    chk({tag, " almost_full"}, s_af, 0);
    chk({tag, " data_out"}, s_dout, 0);
    chk({tag, " overflow"}, s_ovf, 0);
    chk({tag, " underflow"}, s_unf, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         n;

    rst = 1'b1;
    s_flush = 0; s_wr = 0; s_rd = 0; s_din = '0;
    f_flush = 0; f_wr = 0; f_rd = 0; f_din = '0;
    step();
    step();
    rst = 1'b0;
    chk_std_reset("reset");
    chk("fwft reset data_out", f_dout, 0);
    chk("fwft reset empty", f_empty, 1);

    // FWFT: a word written into an empty FIFO falls through without rd_en.
    f_wr = 1; f_din = 8'hA5;
    step();
    f_wr = 0;
    chk("fwft a5 empty", f_empty, 0);
    chk("fwft a5 data_out", f_dout, 8'hA5);
    f_rd = 1;
    step();
    f_rd = 0;
    chk("fwft pop empty", f_empty, 1);
    chk("fwft pop data_out", f_dout, 0);
    f_wr = 1; f_din = 8'h11;
    step();
    f_din = 8'h22;
    step();
    f_wr = 0;
    chk("fwft head 11", f_dout, 8'h11);
    chk("fwft count 2", f_count, 2);
    f_rd = 1;
    step();
    chk("fwft next word 22", f_dout, 8'h22);
    chk("fwft count 1", f_count, 1);
    step();
    f_rd = 0;
    chk("fwft drained data_out", f_dout, 0);
    chk("fwft drained empty", f_empty, 1);

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      s_wr = 1; s_din = 8'(i * 3);
      step();
      chk($sformatf("fill count %0d", i), s_count, i + 1);
      chk($sformatf("fill almost_full %0d", i), s_af, (i + 1) >= 14);
      chk($sformatf("fill full %0d", i), s_full, (i + 1) == 16);
    end
    s_din = 8'h30;
    step();
    s_wr = 0;
    chk("overflow set", s_ovf, 1);
    chk("overflow count", s_count, 16);

    // Drain in standard mode, then one rejected read.
    for (int i = 0; i < 16; i++) begin
      s_rd = 1;
      step();
      chk($sformatf("drain data %0d", i), s_dout, i * 3);
      chk($sformatf("drain count %0d", i), s_count, 15 - i);
      chk($sformatf("drain almost_empty %0d", i), s_ae, (15 - i) <= 2);
    end
    chk("drain empty", s_empty, 1);
    step();
    s_rd = 0;
    chk("underflow set", s_unf, 1);
    chk("underflow data hold", s_dout, 8'h2D);
    chk("underflow count", s_count, 0);

    // Simultaneous read/write at steady count 8, then at full, then at empty.
    pulse_reset();
    chk("sim reset overflow", s_ovf, 0);
    chk("sim reset underflow", s_unf, 0);
    for (int k = 0; k < 8; k++) begin
      s_wr = 1; s_din = 8'(8'h40 + k);
      step();
    end
    for (int j = 0; j < 20; j++) begin
      s_wr = 1; s_rd = 1; s_din = 8'(8'h48 + j);
      step();
      chk($sformatf("steady data %0d", j), s_dout, 8'h40 + j);
      chk($sformatf("steady count %0d", j), s_count, 8);
    end
    s_rd = 0;
    for (int k = 0; k < 8; k++) begin
      s_wr = 1; s_din = 8'(8'h5C + k);
      step();
    end
    chk("refill full", s_full, 1);
    for (int j = 0; j < 2; j++) begin
      s_wr = 1; s_rd = 1; s_din = 8'(8'h64 + j);
      step();
      chk($sformatf("full rw data %0d", j), s_dout, 8'h54 + j);
      chk($sformatf("full rw full %0d", j), s_full, 1);
      chk($sformatf("full rw count %0d", j), s_count, 16);
      chk($sformatf("full rw overflow %0d", j), s_ovf, 0);
    end
    s_wr = 0;
    for (int i = 0; i < 16; i++) begin
      s_rd = 1;
      step();
      chk($sformatf("post-full data %0d", i), s_dout, 8'h56 + i);
    end
    s_wr = 1; s_rd = 1; s_din = 8'h77;
    step();
    s_wr = 0; s_rd = 0;
    chk("empty rw count", s_count, 1);
    chk("empty rw underflow", s_unf, 1);
    chk("empty rw empty", s_empty, 0);
    chk("empty rw data hold", s_dout, 8'h65);

    // Wrap-around against a reference queue: two writes per read, then drain.
    pulse_reset();
    n = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 12; k++) begin
        s_wr = 1; s_din = 8'(8'h80 + n);
        q.push_back(8'(8'h80 + n));
        n++;
        step();
        s_wr = 0;
        if (k % 2 == 1) begin
          s_rd = 1;
          step();
          s_rd = 0;
          exp_d = q.pop_front();
          chk($sformatf("wrap r%0d k%0d", r, k), s_dout, exp_d);
        end
      end
      for (int k = 0; k < 6; k++) begin
        s_rd = 1;
        step();
        s_rd = 0;
        exp_d = q.pop_front();
        chk($sformatf("wrap r%0d drain %0d", r, k), s_dout, exp_d);
      end
    end
    chk("wrap final count", s_count, 0);

    // Flush with count 9 and a concurrent write; sticky underflow must survive.
    s_rd = 1;
    step();
    s_rd = 0;
    chk("pre-flush underflow", s_unf, 1);
    for (int k = 0; k < 9; k++) begin
      s_wr = 1; s_din = 8'(8'hC0 + k);
      step();
    end
    s_wr = 0;
    chk("pre-flush count", s_count, 9);
    s_flush = 1; s_wr = 1; s_din = 8'hEE;
    step();
    s_flush = 0; s_wr = 0;
    chk("flush count", s_count, 0);
    chk("flush empty", s_empty, 1);
    chk("flush full", s_full, 0);
    chk("flush underflow kept", s_unf, 1);
    chk("flush overflow", s_ovf, 0);
    chk("flush data hold", s_dout, 8'hA3);
    s_wr = 1; s_din = 8'h11;
    step();
    s_wr = 0;
    chk("post-flush count", s_count, 1);
    s_rd = 1;
    step();
    s_rd = 0;
    chk("post-flush data", s_dout, 8'h11);
    chk("post-flush count 0", s_count, 0);

    // Reset in the middle of a write burst.
    for (int k = 0; k < 3; k++) begin
      s_wr = 1; s_din = 8'(8'h21 + k);
      step();
    end
    rst = 1; s_din = 8'h24;
    step();
    rst = 0; s_wr = 0;
    chk_std_reset("mid-burst reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
